// File: rtl/pll_phase_cal_if.sv
// rtl/pll_phase_cal_if.sv - read-back tester handshake between phase calibrator and PSRAM datapath
interface pll_phase_cal_if;
    logic test_req;
    logic test_done;
    logic test_pass;

    modport master (output test_req, input test_done, input test_pass);
    modport slave  (input test_req, output test_done, output test_pass);
endinterface

// File: rtl/pll_phase_cal.sv
// rtl/pll_phase_cal.sv - PSRAM PLL reset/lock sequencer and PSDA phase sweep calibrator
module pll_phase_cal #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int SETTLE_CYCLES = 64,
    parameter int TEST_TIMEOUT  = 1024,
    parameter int MIN_WINDOW    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   pll_lock_i,
    output logic                   pll_reset_o,
    output logic [3:0]             pll_psda_o,
    pll_phase_cal_if.master        tst_if,
    output logic                   cal_busy_o,
    output logic                   cal_done_o,
    output logic                   cal_fail_o,
    output logic [3:0]             cal_phase_o,
    output logic [15:0]            pass_map_o
);
    localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CD  = (SETTLE_CYCLES > TEST_TIMEOUT) ? SETTLE_CYCLES : TEST_TIMEOUT;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW      = $clog2(MAX_CYC + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_PLL_RST, S_WAIT_LOCK, S_SETTLE, S_TEST, S_EVAL,
        S_PICK, S_CHOOSE, S_PHASE_SET, S_DONE, S_FAIL
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [3:0]     step_q;
    logic [4:0]     idx_q;
    logic [4:0]     run_len_q;
    logic [4:0]     best_len_q;
    logic [3:0]     run_start_q;
    logic [3:0]     best_start_q;
    logic           lock_meta_q;
    logic           lock_sync_q;
    logic           pll_reset_q;
    logic [3:0]     pll_psda_q;
    logic           test_req_q;
    logic           cal_busy_q;
    logic           cal_done_q;
    logic           cal_fail_q;
    logic [3:0]     cal_phase_q;
    logic [15:0]    pass_map_q;

    logic           restart_d;
    logic           scan_bit_d;
    logic [4:0]     run_len_d;
    logic [4:0]     half_d;
    logic [3:0]     phase_d;

    always_comb begin
        restart_d = 1'b0;
        if (start_i && (state_q == S_IDLE || state_q == S_DONE || state_q == S_FAIL))
            restart_d = 1'b1;
        if (state_q == S_DONE && !lock_sync_q)
            restart_d = 1'b1;
        scan_bit_d = pass_map_q[idx_q[3:0]];
        // The scan covers 32 indices, so an all-pass map would otherwise count past 16.
        run_len_d  = (run_len_q == 5'd16) ? 5'd16 : run_len_q + 5'd1;
        half_d     = (best_len_q - 5'd1) >> 1;
        phase_d    = best_start_q + half_d[3:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            step_q       <= 4'd0;
            idx_q        <= 5'd0;
            run_len_q    <= 5'd0;
            best_len_q   <= 5'd0;
            run_start_q  <= 4'd0;
            best_start_q <= 4'd0;
            lock_meta_q  <= 1'b0;
            lock_sync_q  <= 1'b0;
            pll_reset_q  <= 1'b1;
            pll_psda_q   <= 4'd0;
            test_req_q   <= 1'b0;
            cal_busy_q   <= 1'b0;
            cal_done_q   <= 1'b0;
            cal_fail_q   <= 1'b0;
            cal_phase_q  <= 4'd0;
            pass_map_q   <= 16'h0000;
        end else begin
            lock_meta_q <= pll_lock_i;
            lock_sync_q <= lock_meta_q;
            if (restart_d) begin
                state_q     <= S_PLL_RST;
                cnt_q       <= '0;
                step_q      <= 4'd0;
                pll_psda_q  <= 4'd0;
                pll_reset_q <= 1'b1;
                test_req_q  <= 1'b0;
                cal_busy_q  <= 1'b1;
                cal_done_q  <= 1'b0;
                cal_fail_q  <= 1'b0;
                pass_map_q  <= 16'h0000;
            end else begin
                case (state_q)
                    S_IDLE: pll_reset_q <= 1'b1;
                    S_PLL_RST: begin
                        if (cnt_q == CW'(RST_CYCLES - 1)) begin
                            pll_reset_q <= 1'b0;
                            cnt_q       <= '0;
                            state_q     <= S_WAIT_LOCK;
                        end else cnt_q <= cnt_q + CW'(1);
                    end
                    S_WAIT_LOCK: begin
                        if (lock_sync_q) begin
                            pll_psda_q <= step_q;
                            cnt_q      <= '0;
                            state_q    <= S_SETTLE;
                        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                            cal_busy_q <= 1'b0;
                            cal_fail_q <= 1'b1;
                            pll_psda_q <= 4'd0;
                            state_q    <= S_FAIL;
                        end else cnt_q <= cnt_q + CW'(1);
                    end
                    S_SETTLE: begin
                        if (!lock_sync_q) begin
                            cnt_q   <= '0;
                            state_q <= S_WAIT_LOCK;
                        end else if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
                            test_req_q <= 1'b1;
                            cnt_q      <= '0;
                            state_q    <= S_TEST;
                        end else cnt_q <= cnt_q + CW'(1);
                    end
                    S_TEST: begin
                        if (!lock_sync_q) begin
                            test_req_q <= 1'b0;
                            cnt_q      <= '0;
                            state_q    <= S_WAIT_LOCK;
                        end else if (tst_if.test_done) begin
                            pass_map_q[step_q] <= tst_if.test_pass;
                            test_req_q         <= 1'b0;
                            state_q            <= S_EVAL;
                        end else if (cnt_q == CW'(TEST_TIMEOUT - 1)) begin
                            pass_map_q[step_q] <= 1'b0;
                            test_req_q         <= 1'b0;
                            state_q            <= S_EVAL;
                        end else cnt_q <= cnt_q + CW'(1);
                    end
                    S_EVAL: begin
                        if (step_q == 4'd15) begin
                            idx_q        <= 5'd0;
                            run_len_q    <= 5'd0;
                            best_len_q   <= 5'd0;
                            run_start_q  <= 4'd0;
                            best_start_q <= 4'd0;
                            state_q      <= S_PICK;
                        end else begin
                            step_q     <= step_q + 4'd1;
                            pll_psda_q <= step_q + 4'd1;
                            cnt_q      <= '0;
                            state_q    <= S_SETTLE;
                        end
                    end
                    S_PICK: begin
                        // Scanning twice round the map catches a window that wraps 15 -> 0.
                        if (scan_bit_d) begin
                            run_len_q <= run_len_d;
                            if (run_len_q == 5'd0) run_start_q <= idx_q[3:0];
                            if (run_len_d > best_len_q) begin
                                best_len_q   <= run_len_d;
                                best_start_q <= (run_len_q == 5'd0) ? idx_q[3:0] : run_start_q;
                            end
                        end else run_len_q <= 5'd0;
                        if (idx_q == 5'd31) state_q <= S_CHOOSE;
                        else idx_q <= idx_q + 5'd1;
                    end
                    S_CHOOSE: begin
                        if (best_len_q < 5'(MIN_WINDOW)) begin
                            cal_busy_q <= 1'b0;
                            cal_fail_q <= 1'b1;
                            pll_psda_q <= 4'd0;
                            state_q    <= S_FAIL;
                        end else begin
                            cal_phase_q <= phase_d;
                            pll_psda_q  <= phase_d;
                            cnt_q       <= '0;
                            state_q     <= S_PHASE_SET;
                        end
                    end
                    S_PHASE_SET: begin
                        if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
                            cal_busy_q <= 1'b0;
                            cal_done_q <= 1'b1;
                            state_q    <= S_DONE;
                        end else cnt_q <= cnt_q + CW'(1);
                    end
                    S_DONE, S_FAIL: ;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign pll_reset_o     = pll_reset_q;
    assign pll_psda_o      = pll_psda_q;
    assign tst_if.test_req = test_req_q;
    assign cal_busy_o      = cal_busy_q;
    assign cal_done_o      = cal_done_q;
    assign cal_fail_o      = cal_fail_q;
    assign cal_phase_o     = cal_phase_q;
    assign pass_map_o      = pass_map_q;
endmodule

// File: tb/tb_pll_phase_cal.sv
// tb/tb_pll_phase_cal.sv - scoreboard bench for the PLL phase calibrator
module tb_pll_phase_cal;
    logic        clk;
    logic        rst;
    logic        start;
    logic        pll_lock;
    logic        pll_reset;
    logic [3:0]  pll_psda;
    logic        cal_busy;
    logic        cal_done;
    logic        cal_fail;
    logic [3:0]  cal_phase;
    logic [15:0] pass_map;

    pll_phase_cal_if tif ();

    pll_phase_cal dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .pll_lock_i  (pll_lock),
        .pll_reset_o (pll_reset),
        .pll_psda_o  (pll_psda),
        .tst_if      (tif.master),
        .cal_busy_o  (cal_busy),
        .cal_done_o  (cal_done),
        .cal_fail_o  (cal_fail),
        .cal_phase_o (cal_phase),
        .pass_map_o  (pass_map)
    );

    typedef struct {
        string       tag;
        logic        done;
        logic        fail;
        logic [3:0]  phase;
        logic [3:0]  psda;
        logic [15:0] map;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] pattern  = 16'h0000;
    int          resp_delay  = 2;
    int          silent_step = -1;
    int          silent_len  = 0;
    int          drop_step   = -1;
    logic        dropped     = 1'b0;
    logic        lock_en     = 1'b1;
    int          force_cnt   = 0;
    int          req_count[16];
    logic        req_seen    = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // PSRAM tester model: answers after resp_delay cycles with the pattern bit for the current PSDA.
    initial begin
        int   age;
        logic req_prev;
        age = 0;
        req_prev = 1'b0;
        tif.test_done = 1'b0;
        tif.test_pass = 1'b0;
        forever begin
            @(posedge clk); #1;
            tif.test_done = 1'b0;
            tif.test_pass = 1'b0;
            if (tif.test_req && !req_prev) begin
                req_count[pll_psda]++;
                req_seen = 1'b1;
            end
            if (tif.test_req && int'(pll_psda) == silent_step) silent_len++;
            if (tif.test_req && int'(pll_psda) != silent_step) begin
                age++;
                if (age >= resp_delay) begin
                    tif.test_done = 1'b1;
                    tif.test_pass = pattern[pll_psda];
                    age = 0;
                end
            end else age = 0;
            req_prev = tif.test_req;
        end
    end

    // PLL lock model: locks 10 cycles after reset release, with optional forced drops.
    initial begin
        int lock_age;
        lock_age = 0;
        pll_lock = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (drop_step >= 0 && !dropped && int'(pll_psda) == drop_step && !tif.test_req && !pll_reset) begin
                dropped = 1'b1;
                force_cnt = 6;
            end
            if (force_cnt > 0) begin
                force_cnt--;
                lock_age = 0;
                pll_lock = 1'b0;
            end else if (pll_reset || !lock_en) begin
                lock_age = 0;
                pll_lock = 1'b0;
            end else begin
                if (lock_age < 10) lock_age++;
                pll_lock = (lock_age >= 10);
            end
        end
    end

    task automatic push_exp(input string tag, input logic done, input logic [3:0] phase, input logic [15:0] map);
        exp_t e;
        e.tag   = tag;
        e.done  = done;
        e.fail  = !done;
        e.phase = phase;
        e.psda  = done ? phase : 4'd0;
        e.map   = map;
        sb_q.push_back(e);
    endtask

    task automatic hold_count(input string tag);
        int n;
        n = 0;
        while (pll_reset && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        check({tag, "_rst_hold"}, 32'(n), 32'd16);
    endtask

    task automatic pulse_start(input string tag);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy"}, 32'(cal_busy), 32'd1);
        hold_count(tag);
    endtask

    task automatic wait_result();
        int   n;
        exp_t e;
        n = 0;
        while (!(cal_done || cal_fail) && n < 30000) begin
            @(posedge clk); #1;
            n++;
        end
        e = sb_q.pop_front();
        if (n >= 30000) begin
            check({e.tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check({e.tag, "_done"}, 32'(cal_done), 32'(e.done));
            check({e.tag, "_fail"}, 32'(cal_fail), 32'(e.fail));
            check({e.tag, "_busy_end"}, 32'(cal_busy), 32'd0);
            check({e.tag, "_map"}, 32'(pass_map), 32'(e.map));
            check({e.tag, "_psda"}, 32'(pll_psda), 32'(e.psda));
            if (e.done) check({e.tag, "_phase"}, 32'(cal_phase), 32'(e.phase));
        end
    endtask

    task automatic run_cal(input string tag, input logic [15:0] pat, input logic done,
                           input logic [3:0] phase, input logic [15:0] map);
        pattern = pat;
        resp_delay = $urandom_range(1, 6);
        push_exp(tag, done, phase, map);
        pulse_start(tag);
        wait_result();
    endtask

    initial begin
        int   n;
        exp_t e;
        foreach (req_count[i]) req_count[i] = 0;
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_pll_reset", 32'(pll_reset), 32'd1);
        check("rst_psda", 32'(pll_psda), 32'd0);
        check("rst_test_req", 32'(tif.test_req), 32'd0);
        check("rst_busy", 32'(cal_busy), 32'd0);
        check("rst_done", 32'(cal_done), 32'd0);
        check("rst_fail", 32'(cal_fail), 32'd0);
        check("rst_phase", 32'(cal_phase), 32'd0);
        check("rst_map", 32'(pass_map), 32'd0);
        repeat (4) @(posedge clk);
        #1;

        run_cal("win4_11", 16'h0FF0, 1'b1, 4'd7, 16'h0FF0);
        run_cal("wrap",    16'hC007, 1'b1, 4'd0, 16'hC007);
        run_cal("tie",     16'h0F0F, 1'b1, 4'd1, 16'h0F0F);
        run_cal("allpass", 16'hFFFF, 1'b1, 4'd7, 16'hFFFF);
        run_cal("allfail", 16'h0000, 1'b0, 4'd0, 16'h0000);
        run_cal("single",  16'h0010, 1'b0, 4'd0, 16'h0010);

        foreach (req_count[i]) req_count[i] = 0;
        drop_step = 5;
        dropped = 1'b0;
        run_cal("drop_settle", 16'h0FF0, 1'b1, 4'd7, 16'h0FF0);
        check("drop_fired", 32'(dropped), 32'd1);
        check("drop_retest5", 32'(req_count[5]), 32'd1);
        check("drop_step4", 32'(req_count[4]), 32'd1);
        check("drop_step6", 32'(req_count[6]), 32'd1);
        drop_step = -1;

        foreach (req_count[i]) req_count[i] = 0;
        push_exp("drop_done", 1'b1, 4'd7, 16'h0FF0);
        force_cnt = 6;
        n = 0;
        while (cal_done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("drop_done_cleared", 32'(cal_done), 32'd0);
        check("drop_done_busy", 32'(cal_busy), 32'd1);
        hold_count("drop_done");
        wait_result();
        check("drop_done_resweep0", 32'(req_count[0]), 32'd1);
        check("drop_done_resweep15", 32'(req_count[15]), 32'd1);

        foreach (req_count[i]) req_count[i] = 0;
        silent_step = 3;
        silent_len = 0;
        run_cal("silent3", 16'h0FF8, 1'b1, 4'd7, 16'h0FF0);
        check("silent3_req_len", 32'(silent_len), 32'd1024);
        check("silent3_next_step", 32'(req_count[4]), 32'd1);
        silent_step = -1;

        lock_en = 1'b0;
        req_seen = 1'b0;
        push_exp("lock_to", 1'b0, 4'd0, 16'h0000);
        pulse_start("lock_to");
        n = 0;
        while (!cal_fail && n < 10000) begin
            n++;
            @(posedge clk); #1;
        end
        check("lock_to_low_cycles", 32'(n), 32'd4096);
        wait_result();
        check("lock_to_pll_reset", 32'(pll_reset), 32'd0);
        check("lock_to_no_req", 32'(req_seen), 32'd0);
        lock_en = 1'b1;

        pattern = 16'h0FF0;
        push_exp("rst_mid", 1'b0, 4'd0, 16'h0000);
        pulse_start("rst_mid");
        n = 0;
        while (!tif.test_req && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("rst_mid_req_seen", 32'(tif.test_req), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        e = sb_q.pop_front();
        check({e.tag, "_test_req"}, 32'(tif.test_req), 32'd0);
        check({e.tag, "_pll_reset"}, 32'(pll_reset), 32'd1);
        check({e.tag, "_busy"}, 32'(cal_busy), 32'd0);
        check({e.tag, "_done"}, 32'(cal_done), 32'(e.done));
        check({e.tag, "_fail"}, 32'(cal_fail), 32'd0);
        check({e.tag, "_psda"}, 32'(pll_psda), 32'(e.psda));
        check({e.tag, "_phase"}, 32'(cal_phase), 32'(e.phase));
        check({e.tag, "_map"}, 32'(pass_map), 32'(e.map));
        @(posedge clk); #1;
        rst = 1'b0;
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
